// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: response codes and slave state shared by the AXI-Lite write/read slaves
package axi_wr_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {IDLE, DISPATCH, RESP} state_t;
endpackage

// File: rtl/axi_hold_reg.sv
// axi_hold_reg: one-entry holding register with valid flag, load on handshake, clear on B handshake
module axi_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         full,
  output logic         full_nxt,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d;
  logic         full_q;
  always_comb begin
    full_nxt = clr ? 1'b0 : (load ? 1'b1 : full_q);
    q_d      = load ? d : q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      q      <= '0;
    end else begin
      full_q <= full_nxt;
      q      <= q_d;
    end
  end
  assign full = full_q;
endmodule

// File: rtl/axi_lite_wr_mc_slave.sv
// axi_lite_wr_mc_slave: AXI4-Lite write slave fanning single-word writes out to N_CH TX FIFOs
module axi_lite_wr_mc_slave
  import axi_wr_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                N_CH         = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                CH_STRIDE    = 4,
  parameter int                FULL_TIMEOUT = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [N_CH-1:0]       ch_full,
  output logic [N_CH-1:0]       ch_wr_en,
  output logic [DATA_W-1:0]     ch_data
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(FULL_TIMEOUT + 1);
  localparam int SH     = $clog2(CH_STRIDE);
  localparam int IDX_W  = N_CH > 1 ? $clog2(N_CH) : 1;
  state_t              state_q, state_d;
  resp_t               bresp_q, bresp_d, verdict, resp_sel;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [N_CH-1:0]     wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   data_q, data_d, wdata;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STRB_W-1:0]   wstrb;
  logic [ADDR_W-1:0]   addr, off, idx_full;
  logic [IDX_W-1:0]    idx;
  logic                aw_full, aw_full_nxt, w_full, w_full_nxt, b_hs;
  logic                full_sel, timeout, done, do_wr;
  assign b_hs = bvalid_q & BREADY;
  axi_hold_reg #(.W(ADDR_W)) u_aw (
    .clk(ACLK), .rst(ARESET), .load(AWVALID & awready_q), .clr(b_hs),
    .d(AWADDR), .full(aw_full), .full_nxt(aw_full_nxt), .q(addr)
  );
  axi_hold_reg #(.W(DATA_W + STRB_W)) u_w (
    .clk(ACLK), .rst(ARESET), .load(WVALID & wready_q), .clr(b_hs),
    .d({WSTRB, WDATA}), .full(w_full), .full_nxt(w_full_nxt), .q({wstrb, wdata})
  );
  // Decode checks are prioritised: range, alignment, strobes, then FIFO space.
  always_comb begin
    off      = addr - BASE_ADDR;
    idx_full = off >> SH;
    idx      = idx_full[IDX_W-1:0];
    verdict  = (addr < BASE_ADDR || idx_full >= ADDR_W'(N_CH)) ? DECERR :
               ((off & ADDR_W'(CH_STRIDE - 1)) != '0 || !(&wstrb)) ? SLVERR : OKAY;
    full_sel = ch_full[idx];
    timeout  = cnt_q == CNT_W'(FULL_TIMEOUT);
    resp_sel = verdict != OKAY ? verdict : (full_sel ? SLVERR : OKAY);
    do_wr    = state_q == DISPATCH && verdict == OKAY && !full_sel;
    done     = state_q == DISPATCH && (verdict != OKAY || !full_sel || timeout);
  end
  always_comb begin
    state_d = state_q == IDLE     ? ((aw_full_nxt && w_full_nxt) ? DISPATCH : IDLE) :
              state_q == DISPATCH ? (done ? RESP : DISPATCH) :
                                    (b_hs ? IDLE : RESP);
  end
  always_comb begin
    awready_d = state_d == IDLE && !aw_full_nxt;
    wready_d  = state_d == IDLE && !w_full_nxt;
    bvalid_d  = done | (bvalid_q & ~b_hs);
    bresp_d   = done ? resp_sel : bresp_q;
    wr_en_d   = do_wr ? N_CH'(1) << idx : '0;
    data_d    = do_wr ? wdata : data_q;
    cnt_d     = b_hs ? '0 : (state_q == DISPATCH && !timeout) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      wr_en_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end
  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ch_wr_en = wr_en_q;
  assign ch_data  = data_q;
  // aw_full/w_full are only observed through their next-state view
  logic unused_ok;
  assign unused_ok = aw_full ^ w_full;
endmodule

// File: tb/tb_axi_lite_wr_mc_slave.sv
// tb_axi_lite_wr_mc_slave: table vectors, randomized transactions vs. a rule-based model, reset corner case
module tb_axi_lite_wr_mc_slave;
  localparam int FT = 16, NCH = 4, STRIDE = 4;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ch_data;
  logic        AWVALID = 1'b0, AWREADY, WVALID = 1'b0, WREADY, BVALID, BREADY = 1'b0;
  logic [3:0]  WSTRB = '0, ch_full = '0, ch_wr_en;
  logic [1:0]  BRESP;
  int          cyc = 0, n_checks = 0, n_err = 0;

  axi_lite_wr_mc_slave #(
    .DATA_W(32), .ADDR_W(32), .N_CH(NCH), .BASE_ADDR(32'h0), .CH_STRIDE(STRIDE), .FULL_TIMEOUT(FT)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .BRESP(BRESP),
    .BVALID(BVALID), .BREADY(BREADY), .ch_full(ch_full), .ch_wr_en(ch_wr_en), .ch_data(ch_data)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_d, w_d, f, bd;
    logic [1:0]  resp;
    logic [3:0]  wr;
    int          lat;
  } vec_t;

  task automatic step();
    @(posedge ACLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Spec rules applied directly to the byte address; f = DISPATCH cycles the target FIFO stays full.
  function automatic void model(input logic [31:0] a, input logic [3:0] s, input int f,
                                output logic [1:0] r, output logic [3:0] w, output int wt);
    longint off = longint'(a) - 0;
    w = '0;
    wt = 0;
    if (off < 0 || off / STRIDE >= NCH) r = 2'b11;
    else if (off % STRIDE != 0) r = 2'b10;
    else if (s != 4'hF) r = 2'b10;
    else if (f > FT) begin r = 2'b10; wt = FT; end
    else begin r = 2'b00; w = 4'(1 << (off / STRIDE)); wt = f; end
  endfunction

  // t = 0 is the first cycle after the previous B handshake; lat = cycle BVALID first rises.
  task automatic run_txn(input vec_t v);
    int dd = (v.aw_d > v.w_d ? v.aw_d : v.w_d) + 1;
    int r  = v.lat + v.bd;
    for (int t = 0; t <= r; t++) begin
      step();
      AWVALID = t == v.aw_d;
      AWADDR  = v.addr;
      WVALID  = t == v.w_d;
      WDATA   = v.data;
      WSTRB   = v.strb;
      BREADY  = t >= r;
      ch_full = (t >= dd && t < dd + v.f) ? 4'hF : (4'($urandom) & ~v.wr);
      chk("awready", AWREADY, t <= v.aw_d);
      chk("wready", WREADY, t <= v.w_d);
      chk("bvalid", BVALID, t >= v.lat);
      if (t >= v.lat) chk("bresp", BRESP, v.resp);
      chk("ch_wr_en", ch_wr_en, t == v.lat ? v.wr : 4'h0);
      if (t == v.lat && v.wr != 0) chk("ch_data", ch_data, v.data);
    end
  endtask

  task automatic idle();
    step();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    ch_full = '0;
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{32'h4,        32'hDEADBEEF, 4'hF, 0, 0, 0,  0,  2'b00, 4'b0010, 2};
    tbl[1] = '{32'hC,        32'h12345678, 4'hF, 3, 0, 0,  0,  2'b00, 4'b1000, 5};
    tbl[2] = '{32'h10,       32'h11111111, 4'hF, 0, 0, 0,  0,  2'b11, 4'b0000, 2};
    tbl[3] = '{32'h6,        32'h22222222, 4'hF, 0, 0, 0,  0,  2'b10, 4'b0000, 2};
    tbl[4] = '{32'h0,        32'h33333333, 4'h3, 0, 0, 0,  0,  2'b10, 4'b0000, 2};
    tbl[5] = '{32'h0,        32'h44444444, 4'hF, 0, 0, 40, 0,  2'b10, 4'b0000, 18};
    tbl[6] = '{32'h0,        32'h55555555, 4'hF, 0, 0, 5,  0,  2'b00, 4'b0001, 7};
    tbl[7] = '{32'h8,        32'h66666666, 4'hF, 0, 2, 0,  10, 2'b00, 4'b0100, 4};
    tbl[8] = '{32'hFFFFFFFC, 32'h77777777, 4'hF, 1, 1, 0,  1,  2'b11, 4'b0000, 3};
    tbl[9] = '{32'h4,        32'h88888888, 4'hF, 2, 0, 3,  2,  2'b00, 4'b0010, 7};

    step();
    step();
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_ch_wr_en", ch_wr_en, 4'h0);
    chk("rst_ch_data", ch_data, 32'h0);
    ARESET = 1'b0;

    foreach (tbl[i]) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 9);
      rv.addr = sel < 6 ? 32'(sel * 4) :
                sel == 6 ? 32'($urandom_range(0, 3) * 4 + $urandom_range(1, 3)) :
                sel == 7 ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) :
                32'($urandom_range(0, 3) * 4);
      rv.data = $urandom;
      rv.strb = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF;
      rv.aw_d = $urandom_range(0, 3);
      rv.w_d  = $urandom_range(0, 3);
      rv.f    = $urandom_range(0, 4) == 0 ? 40 : $urandom_range(0, 6);
      rv.bd   = $urandom_range(0, 3);
      model(rv.addr, rv.strb, rv.f, rv.resp, rv.wr, rv.lat);
      rv.lat += (rv.aw_d > rv.w_d ? rv.aw_d : rv.w_d) + 2;
      run_txn(rv);
    end

    // Reset while a write is stuck in DISPATCH on a full FIFO
    idle();
    AWVALID = 1'b1;
    AWADDR  = 32'h0;
    WVALID  = 1'b1;
    WDATA   = 32'hCAFE0001;
    WSTRB   = 4'hF;
    ch_full = 4'hF;
    step();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("disp_awready", AWREADY, 1'b0);
    step();
    ARESET = 1'b1;
    step();
    chk("mid_rst_awready", AWREADY, 1'b0);
    chk("mid_rst_wready", WREADY, 1'b0);
    chk("mid_rst_bvalid", BVALID, 1'b0);
    chk("mid_rst_bresp", BRESP, 2'b00);
    chk("mid_rst_ch_wr_en", ch_wr_en, 4'h0);
    chk("mid_rst_ch_data", ch_data, 32'h0);
    ARESET  = 1'b0;
    ch_full = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_ch_wr_en", ch_wr_en, 4'h0);
      chk("post_rst_bvalid", BVALID, 1'b0);
      chk("post_rst_awready", AWREADY, 1'b1);
      chk("post_rst_wready", WREADY, 1'b1);
    end
    rv = '{32'h8, 32'h0BADF00D, 4'hF, 1, 0, 0, 0, 2'b00, 4'b0100, 3};
    run_txn(rv);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule

// File: doc/axi_lite_wr_mc_slave.md
# axi_lite_wr_mc_slave

AXI4-Lite write-only slave that accepts address and data beats independently, decodes the address onto one of N_CH downstream TX FIFO write ports, and returns a B response. It replaces the fixed two-target write slave with a parametrised channel count and data width. It adds full-byte-strobe checking, a misalignment check, and a bounded wait on a full FIFO. It sits between the AXI interconnect and the per-channel TX FIFOs.

## Interface
Parameters:
- DATA_W, 32, AXI data width and FIFO word width; multiple of 8.
- ADDR_W, 32, AXI address width.
- N_CH, 4, number of FIFO channels; 1..16.
- BASE_ADDR, 32'h0, address of channel 0.
- CH_STRIDE, 4, byte distance between channel addresses; power of two, at least DATA_W/8.
- FULL_TIMEOUT, 16, number of DISPATCH cycles to wait on a full FIFO before an SLVERR response; at least 1.

Ports:
- ACLK, in, 1, the single clock.
- ARESET, in, 1, reset; synchronous, active-high.
- AWADDR, in, ADDR_W, write address.
- AWVALID / AWREADY, in / out, 1, AW handshake.
- WDATA, in, DATA_W, write data.
- WSTRB, in, DATA_W/8, byte strobes.
- WVALID / WREADY, in / out, 1, W handshake.
- BRESP, out, 2, write response.
- BVALID / BREADY, out / in, 1, B handshake.
- ch_full, in, N_CH, per-channel FIFO full flag.
- ch_wr_en, out, N_CH, one-hot single-cycle FIFO write pulse.
- ch_data, out, DATA_W, shared write data to all FIFOs; valid while ch_wr_en is set.

## Operation
- AW and W beats are captured independently, in either order, each into a one-entry holding register. AWREADY is high when the AW holder is empty and state is IDLE; WREADY is the same for the W holder. Both READY signals are registered, with no combinational path from VALID.
- IDLE: when both holders are full, go to DISPATCH.
- DISPATCH: decode the held address as idx = (addr - BASE_ADDR) / CH_STRIDE.
  - Address below BASE_ADDR or idx >= N_CH: DECERR (2'b11), no write.
  - addr offset not a multiple of CH_STRIDE: SLVERR (2'b10), no write.
  - WSTRB not all ones: SLVERR, no write. Partial words are never written.
  - ch_full[idx] = 0: ch_wr_en[idx] <= 1, ch_data <= held data, OKAY (2'b00).
  - ch_full[idx] = 1: wait cycles are counted. After FULL_TIMEOUT consecutive full cycles, respond SLVERR with no write.
  - Error checks are applied in the order listed.
  - Every exit from DISPATCH registers BVALID <= 1 and the chosen BRESP, then goes to RESP.
- RESP: hold BVALID and BRESP stable until BREADY. On BVALID & BREADY: clear both holders and the wait counter, BVALID <= 0, go to IDLE.
- Only one transaction is in flight. New AW or W beats are blocked from DISPATCH entry until the cycle after the B handshake.

## Timing
- Reset values: AWREADY = 0 on the reset cycle, then 1 in IDLE. WREADY is the same. BVALID = 0, BRESP = 2'b00, ch_wr_en = 0, ch_data = 0. State is IDLE, holders are empty, counter = 0.
- Both handshakes in cycle T with FIFO not full:
  - DISPATCH in T+1.
  - ch_wr_en and BVALID high in T+2.
  - ch_wr_en is high for exactly one cycle.
- AW in T and W in T+k: DISPATCH in T+k+1.
- Full-FIFO timeout: with FIFO full throughout, BVALID = SLVERR in T+2+FULL_TIMEOUT. If the FIFO goes not-full at DISPATCH cycle j < FULL_TIMEOUT, the write occurs normally one cycle later.
- B handshake in cycle R: AWREADY and WREADY high in R+1.
- ARESET asserted mid-transaction: everything returns to reset values next edge, the held beat is discarded, and no ch_wr_en pulse is issued.
- Wait counter width is $clog2(FULL_TIMEOUT+1). It saturates and never wraps.

## Structure
- Package axi_wr_pkg:
  - resp_t: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - state_t: IDLE, DISPATCH, RESP.
  - Shared with the future read slave.
- Sub-module axi_hold_reg, parametrised by width, instantiated twice (AW and W). It provides a one-entry register with valid flag, load on handshake, and clear on B handshake.

## Test plan
- AW = 0x4 and W = 0xDEADBEEF, WSTRB = 4'hF, in the same cycle with defaults: ch_wr_en = 4'b0010 and ch_data = 0xDEADBEEF in T+2, BRESP = OKAY.
- W in T, AW = 0xC in T+3: ch_wr_en = 4'b1000 in T+5, exactly one pulse, BRESP = OKAY.
- AW = 0x10 (idx 4, out of range): BRESP = DECERR, no ch_wr_en. Then AW = 0x6: BRESP = SLVERR, no write.
- WSTRB = 4'h3 to 0x0: BRESP = SLVERR, no write.
- ch_full[0] held high, write to 0x0: BVALID = SLVERR in T+18, no write. Repeat with ch_full[0] released after 5 DISPATCH cycles: write happens in the cycle after release, BRESP = OKAY.
- BREADY held low 10 cycles: BVALID and BRESP stable, AWREADY = 0 throughout. Then ARESET during a second DISPATCH: all outputs return to reset values, no ch_wr_en pulse.
